// File: rtl/flash_bus_arbiter.sv
// flash_bus_arbiter
// Shares one flash controller bus slave between the instruction-fetch port (m0)
// and the load/store port (m1). One access is in flight at a time. Each access
// runs issue -> wait for s_stall to rise -> wait for s_stall to fall -> ack.
// If s_stall never rises within START_TO cycles, the access is aborted with err.
// Build option: define FLASH_ARB_RR_EN for round-robin arbitration.
// Without it, m1 has fixed priority over m0.
module flash_bus_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int START_TO = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                m0_req,
  input  logic                m0_we,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [DATA_W/8-1:0] m0_mask,
  output logic                m0_ack,
  output logic                m0_err,
  output logic [DATA_W-1:0]   m0_rdata,
  input  logic                m1_req,
  input  logic                m1_we,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_mask,
  output logic                m1_ack,
  output logic                m1_err,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                s_read,
  output logic                s_write,
  output logic [ADDR_W-1:0]   s_address,
  output logic [DATA_W-1:0]   s_data_w,
  output logic [DATA_W/8-1:0] s_mask,
  input  logic [DATA_W-1:0]   s_data_r,
  input  logic                s_stall
);

  localparam int MASK_W = DATA_W / 8;
  localparam int CNT_W  = $clog2(START_TO + 1);
  // Last WAIT_BUSY cycle index before the start timeout fires (counter starts at 0).
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(START_TO - 1);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_t;

  state_t              state_r, state_s;
  logic                sel_m1_s;
  logic                win_we_s;
  logic [ADDR_W-1:0]   win_addr_s;
  logic [DATA_W-1:0]   win_wdata_s;
  logic [MASK_W-1:0]   win_mask_s;
  logic                latch_s, rd_stb_s, wr_stb_s, ack_s, err_s, cap_s, cnt_clr_s, cnt_inc_s;

  logic                owner_r;
  logic                we_r;
  logic [ADDR_W-1:0]   addr_r;
  logic [DATA_W-1:0]   wdata_r;
  logic [MASK_W-1:0]   mask_r;
  logic [CNT_W-1:0]    cnt_r;
  logic                s_read_r, s_write_r;
  logic                m0_ack_r, m1_ack_r, m0_err_r, m1_err_r;
  logic [DATA_W-1:0]   m0_rdata_r, m1_rdata_r;

`ifdef FLASH_ARB_RR_EN
  logic grant_r;  // 1 = m1 was granted last

  // Round-robin pick: on contention the master not granted last wins.
  always_comb begin
    sel_m1_s = 1'b0;
    if (m0_req && m1_req) begin
      sel_m1_s = ~grant_r;
    end else begin
      sel_m1_s = m1_req;
    end
  end

  // Remember the last granted master, updated on every IDLE->ISSUE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_r <= 1'b0;
    end else if (latch_s) begin
      grant_r <= sel_m1_s;
    end else begin
      grant_r <= grant_r;
    end
  end
`else
  // Fixed priority pick: the data port beats instruction fetch.
  always_comb begin
    sel_m1_s = 1'b0;
    if (m1_req) begin
      sel_m1_s = 1'b1;
    end else begin
      sel_m1_s = 1'b0;
    end
  end
`endif

  // Route the winner's request fields towards the latch.
  always_comb begin
    win_we_s    = m0_we;
    win_addr_s  = m0_addr;
    win_wdata_s = m0_wdata;
    win_mask_s  = m0_mask;
    if (sel_m1_s) begin
      win_we_s    = m1_we;
      win_addr_s  = m1_addr;
      win_wdata_s = m1_wdata;
      win_mask_s  = m1_mask;
    end else begin
      win_we_s    = m0_we;
      win_addr_s  = m0_addr;
      win_wdata_s = m0_wdata;
      win_mask_s  = m0_mask;
    end
  end

  // Access sequencer state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state and next-value decode for strobes, acks, counter and capture.
  always_comb begin
    state_s   = state_r;
    latch_s   = 1'b0;
    rd_stb_s  = s_read_r;
    wr_stb_s  = s_write_r;
    ack_s     = 1'b0;
    err_s     = 1'b0;
    cap_s     = 1'b0;
    cnt_clr_s = 1'b0;
    cnt_inc_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (m0_req || m1_req) begin
          state_s  = ST_ISSUE;
          latch_s  = 1'b1;
          rd_stb_s = ~win_we_s;
          wr_stb_s = win_we_s;
        end else begin
          rd_stb_s = 1'b0;
          wr_stb_s = 1'b0;
        end
      end
      ST_ISSUE: begin
        state_s   = ST_WAIT_BUSY;
        cnt_clr_s = 1'b1;
      end
      ST_WAIT_BUSY: begin
        if (s_stall) begin
          state_s  = ST_WAIT_DONE;
          rd_stb_s = 1'b0;
          wr_stb_s = 1'b0;
        end else if (cnt_r == CNT_LAST) begin
          // Slave never acknowledged the strobe: abort with error.
          state_s  = ST_IDLE;
          rd_stb_s = 1'b0;
          wr_stb_s = 1'b0;
          ack_s    = 1'b1;
          err_s    = 1'b1;
        end else begin
          cnt_inc_s = 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (!s_stall) begin
          state_s = ST_IDLE;
          ack_s   = 1'b1;
          cap_s   = ~we_r;
        end else begin
          state_s = ST_WAIT_DONE;
        end
      end
      default: begin
        state_s  = ST_IDLE;
        rd_stb_s = 1'b0;
        wr_stb_s = 1'b0;
      end
    endcase
  end

  // Latch the granted request so later master-side changes are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_r <= 1'b0;
      we_r    <= 1'b0;
      addr_r  <= {ADDR_W{1'b0}};
      wdata_r <= {DATA_W{1'b0}};
      mask_r  <= {MASK_W{1'b0}};
    end else if (latch_s) begin
      owner_r <= sel_m1_s;
      we_r    <= win_we_s;
      addr_r  <= win_addr_s;
      wdata_r <= win_wdata_s;
      mask_r  <= win_mask_s;
    end else begin
      owner_r <= owner_r;
      we_r    <= we_r;
      addr_r  <= addr_r;
      wdata_r <= wdata_r;
      mask_r  <= mask_r;
    end
  end

  // Start-timeout counter, cleared on entry to WAIT_BUSY.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (cnt_clr_s) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (cnt_inc_s) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Registered slave strobes and per-master ack/err pulses (only the owner sees them).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_read_r  <= 1'b0;
      s_write_r <= 1'b0;
      m0_ack_r  <= 1'b0;
      m1_ack_r  <= 1'b0;
      m0_err_r  <= 1'b0;
      m1_err_r  <= 1'b0;
    end else begin
      s_read_r  <= rd_stb_s;
      s_write_r <= wr_stb_s;
      m0_ack_r  <= ack_s & ~owner_r;
      m1_ack_r  <= ack_s & owner_r;
      m0_err_r  <= err_s & ~owner_r;
      m1_err_r  <= err_s & owner_r;
    end
  end

  // Read data capture; each master's copy holds until its next successful read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m0_rdata_r <= {DATA_W{1'b0}};
      m1_rdata_r <= {DATA_W{1'b0}};
    end else if (cap_s) begin
      m0_rdata_r <= owner_r ? m0_rdata_r : s_data_r;
      m1_rdata_r <= owner_r ? s_data_r : m1_rdata_r;
    end else begin
      m0_rdata_r <= m0_rdata_r;
      m1_rdata_r <= m1_rdata_r;
    end
  end

  assign s_read    = s_read_r;
  assign s_write   = s_write_r;
  assign s_address = addr_r;
  assign s_data_w  = wdata_r;
  assign s_mask    = mask_r;
  assign m0_ack    = m0_ack_r;
  assign m1_ack    = m1_ack_r;
  assign m0_err    = m0_err_r;
  assign m1_err    = m1_err_r;
  assign m0_rdata  = m0_rdata_r;
  assign m1_rdata  = m1_rdata_r;

endmodule

// File: tb/tb_flash_bus_arbiter.sv
// Testbench for flash_bus_arbiter: a table of single accesses, directed
// multi-cycle sequences, and a randomized phase against a memory reference model.
module tb_flash_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  m_req = 2'b00;
  logic [1:0]  m_we  = 2'b00;
  logic [31:0] m_addr [2];
  logic [31:0] m_wdata [2];
  logic [3:0]  m_mask [2];
  logic        m0_ack, m1_ack, m0_err, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_read, s_write;
  logic [31:0] s_address, s_data_w, s_data_r;
  logic [3:0]  s_mask;
  logic        s_stall;

  int checks = 0;
  int errors = 0;

  flash_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .START_TO(15)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m_req[0]), .m0_we(m_we[0]), .m0_addr(m_addr[0]), .m0_wdata(m_wdata[0]),
    .m0_mask(m_mask[0]), .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
    .m1_req(m_req[1]), .m1_we(m_we[1]), .m1_addr(m_addr[1]), .m1_wdata(m_wdata[1]),
    .m1_mask(m_mask[1]), .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
    .s_read(s_read), .s_write(s_write), .s_address(s_address), .s_data_w(s_data_w),
    .s_mask(s_mask), .s_data_r(s_data_r), .s_stall(s_stall)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // ---------------- flash slave model ----------------
  logic [31:0] mem [1024];
  bit          wvalid [1024];
  int          sl_dly = 0, sl_busy = 1;
  bit          sl_rand = 1'b0, sl_dead = 1'b0;
  logic        prev_stb;
  int          ph, dcnt, bcnt;
  logic [9:0]  sa;
  logic        swe;
  logic [31:0] swd;
  logic [3:0]  smk;

  function automatic logic [31:0] dflt(input logic [9:0] a);
    logic [31:0] v;
    v = {22'd0, a} * 32'h9E3779B1;
    if (a == 10'h100) v = 32'hDEADBEEF;
    return v;
  endfunction

  function automatic logic [31:0] flash_rd(input logic [9:0] a);
    return wvalid[a] ? mem[a] : dflt(a);
  endfunction

  // Slave: accepts on strobe rise, waits dly cycles, then stalls for busy cycles.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_stb <= 1'b0; ph <= 0; dcnt <= 0; bcnt <= 0;
      s_stall <= 1'b0; s_data_r <= 32'd0;
    end else begin
      prev_stb <= s_read | s_write;
      case (ph)
        0: if ((s_read || s_write) && !prev_stb && !sl_dead) begin
             ph   <= 1;
             dcnt <= sl_rand ? int'($urandom_range(0, 3)) : sl_dly;
             bcnt <= sl_rand ? int'($urandom_range(1, 5)) : sl_busy;
             sa   <= s_address[9:0];
             swe  <= s_write;
             swd  <= s_data_w;
             smk  <= s_mask;
           end
        1: if (dcnt == 0) begin s_stall <= 1'b1; ph <= 2; end
           else dcnt <= dcnt - 1;
        2: if (bcnt <= 1) begin
             s_stall <= 1'b0;
             ph <= 0;
             if (swe) begin
               mem[sa] <= (flash_rd(sa) & ~{{8{smk[3]}}, {8{smk[2]}}, {8{smk[1]}}, {8{smk[0]}}})
                        | (swd & {{8{smk[3]}}, {8{smk[2]}}, {8{smk[1]}}, {8{smk[0]}}});
               wvalid[sa] <= 1'b1;
             end else begin
               s_data_r <= flash_rd(sa);
             end
           end else bcnt <= bcnt - 1;
        default: ph <= 0;
      endcase
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
    end
  endtask

  bit          r_got, r_err, r_rd_stb, r_wr_stb;
  logic [31:0] r_rd, r_addr, r_data;
  logic [3:0]  r_mask;
  int          r_lat, r_stb, r_other, r_unst;

  // One access from master n; fields are scrambled once the strobe is seen.
  task automatic run_access(input int n, input bit we, input logic [31:0] a,
                            input logic [31:0] wd, input logic [3:0] mk);
    bit first;
    @(negedge clk);
    m_we[n] = we; m_addr[n] = a; m_wdata[n] = wd; m_mask[n] = mk; m_req[n] = 1'b1;
    r_got = 0; r_err = 0; r_rd = 32'd0; r_lat = 0; r_stb = 0; r_other = 0; r_unst = 0; first = 1;
    while (!r_got && r_lat < 200) begin
      @(negedge clk);
      r_lat++;
      if (s_read || s_write) begin
        r_stb++;
        if (first) begin
          first = 0;
          r_addr = s_address; r_data = s_data_w; r_mask = s_mask;
          r_rd_stb = s_read; r_wr_stb = s_write;
          m_addr[n] = ~a; m_wdata[n] = ~wd; m_mask[n] = ~mk;
        end else if ({s_address, s_data_w, s_mask, s_read, s_write} !==
                     {r_addr, r_data, r_mask, r_rd_stb, r_wr_stb}) begin
          r_unst++;
        end
      end
      if ((n == 0) ? m1_ack : m0_ack) r_other++;
      if ((n == 0) ? m0_ack : m1_ack) begin
        r_got = 1;
        r_err = (n == 0) ? m0_err : m1_err;
        r_rd  = (n == 0) ? m0_rdata : m1_rdata;
        m_req[n] = 1'b0;
      end
    end
    m_req[n] = 1'b0;
  endtask

  // Wait until the strobe has risen and fallen again (WAIT_DONE entered).
  task automatic wait_strobe_fall(output bit ok);
    bit seen;
    seen = 0; ok = 0;
    for (int k = 0; k < 60 && !ok; k++) begin
      @(negedge clk);
      if (s_read || s_write) seen = 1;
      else if (seen) ok = 1;
    end
  endtask

  typedef struct {
    int          mst;
    bit          we;
    logic [31:0] addr, wdata;
    logic [3:0]  mask;
    int          dly, busy;
    logic [31:0] exp_rdata;
    bit          exp_err;
    int          exp_lat, exp_stb;
  } vec_t;

  vec_t        tbl [6];
  int          order [4];
  int          exp_ord [4];
  int          nord, acks0, acks1, rises;
  bit          ok, prev_rd;
  logic [31:0] exp_rd [2];
  logic [31:0] rmem [16];
  bit          rval [16];
  bit          pend [2];
  int          quiet [2];
  logic [31:0] exp_v;

  initial begin
    // mst we addr wdata mask dly busy exp_rdata err lat stb
    tbl[0] = '{0, 1'b0, 32'h100, 32'h0,        4'h0, 0, 4, 32'hDEADBEEF, 1'b0, 8, 3};
    tbl[1] = '{1, 1'b1, 32'h40,  32'h12345678, 4'hF, 0, 1, 32'h0,        1'b0, 5, 3};
    tbl[2] = '{1, 1'b0, 32'h40,  32'h0,        4'h0, 1, 2, 32'h12345678, 1'b0, 7, 4};
    tbl[3] = '{0, 1'b1, 32'h40,  32'hAAAA5555, 4'h3, 2, 3, 32'hDEADBEEF, 1'b0, 9, 5};
    tbl[4] = '{0, 1'b0, 32'h40,  32'h0,        4'h0, 0, 1, 32'h12345555, 1'b0, 5, 3};
    tbl[5] = '{1, 1'b0, 32'h100, 32'h0,        4'h0, 3, 2, 32'hDEADBEEF, 1'b0, 9, 6};
    for (int i = 0; i < 2; i++) begin
      m_addr[i] = 32'd0; m_wdata[i] = 32'd0; m_mask[i] = 4'd0;
    end

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_flags", {m0_ack, m1_ack, m0_err, m1_err, s_read, s_write}, 32'd0);
    chk("rst_m0_rdata", m0_rdata, 32'd0);
    chk("rst_m1_rdata", m1_rdata, 32'd0);
    chk("rst_s_fields", s_address | s_data_w | {28'd0, s_mask}, 32'd0);
    rst = 1'b0;

    // Table of single accesses
    for (int i = 0; i < 6; i++) begin
      sl_dly = tbl[i].dly; sl_busy = tbl[i].busy;
      run_access(tbl[i].mst, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].mask);
      chk($sformatf("v%0d_ack", i), r_got, 1);
      chk($sformatf("v%0d_err", i), r_err, tbl[i].exp_err);
      chk($sformatf("v%0d_rdata", i), r_rd, tbl[i].exp_rdata);
      chk($sformatf("v%0d_latency", i), r_lat, tbl[i].exp_lat);
      chk($sformatf("v%0d_strobe_cycles", i), r_stb, tbl[i].exp_stb);
      chk($sformatf("v%0d_other_ack", i), r_other, 0);
      chk($sformatf("v%0d_field_stable", i), r_unst, 0);
      chk($sformatf("v%0d_s_address", i), r_addr, tbl[i].addr);
      chk($sformatf("v%0d_strobe_kind", i), {r_rd_stb, r_wr_stb}, {~tbl[i].we, tbl[i].we});
      if (tbl[i].we) begin
        chk($sformatf("v%0d_s_data_w", i), r_data, tbl[i].wdata);
        chk($sformatf("v%0d_s_mask", i), r_mask, tbl[i].mask);
      end
    end

    // Start timeout: slave never stalls
    sl_dead = 1'b1;
    run_access(0, 1'b0, 32'h8, 32'h0, 4'h0);
    chk("to_ack", r_got, 1);
    chk("to_err", r_err, 1);
    chk("to_strobe_cycles", r_stb, 16);
    chk("to_latency", r_lat, 17);
    chk("to_rdata_kept", r_rd, 32'h12345555);
    sl_dead = 1'b0;

    // m0 drops req during WAIT_DONE
    sl_dly = 0; sl_busy = 4;
    @(negedge clk);
    m_we[0] = 1'b0; m_addr[0] = 32'h100; m_req[0] = 1'b1;
    wait_strobe_fall(ok);
    chk("drop_reached_wait_done", ok, 1);
    m_req[0] = 1'b0;
    acks0 = 0; acks1 = 0; rises = 0; prev_rd = s_read;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      acks0 += m0_ack; acks1 += m1_ack;
      if (s_read && !prev_rd) rises++;
      prev_rd = s_read;
    end
    chk("drop_m0_ack_count", acks0, 1);
    chk("drop_m1_ack_count", acks1, 0);
    chk("drop_extra_read", rises, 0);
    chk("drop_rdata", m0_rdata, 32'hDEADBEEF);

    // Reset asserted in WAIT_DONE
    sl_dly = 0; sl_busy = 6;
    @(negedge clk);
    m_we[0] = 1'b0; m_addr[0] = 32'h40; m_req[0] = 1'b1;
    wait_strobe_fall(ok);
    chk("rstmid_reached_wait_done", ok, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rstmid_flags", {m0_ack, m1_ack, m0_err, m1_err, s_read, s_write}, 32'd0);
    chk("rstmid_m0_rdata", m0_rdata, 32'd0);
    chk("rstmid_s_fields", s_address | s_data_w | {28'd0, s_mask}, 32'd0);
    m_req[0] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    sl_busy = 1;
    run_access(0, 1'b0, 32'h40, 32'h0, 4'h0);
    chk("rstmid_after_ack", r_got, 1);
    chk("rstmid_after_rdata", r_rd, 32'h12345555);
    chk("rstmid_after_latency", r_lat, 5);

    // Contention: both request and hold for four accesses
`ifdef FLASH_ARB_RR_EN
    exp_ord = '{1, 0, 1, 0};
    exp_rd[0] = dflt(10'h10);
`else
    exp_ord = '{1, 1, 1, 1};
    exp_rd[0] = 32'h12345555;
`endif
    exp_rd[1] = dflt(10'h20);
    sl_dly = 0; sl_busy = 1; nord = 0;
    @(negedge clk);
    m_we = 2'b00; m_addr[0] = 32'h10; m_addr[1] = 32'h20; m_req = 2'b11;
    for (int k = 0; k < 200 && nord < 4; k++) begin
      @(negedge clk);
      if (m0_ack && nord < 4) begin order[nord] = 0; nord++; end
      if (m1_ack && nord < 4) begin order[nord] = 1; nord++; end
    end
    m_req = 2'b00;
    chk("arb_ack_count", nord, 4);
    for (int i = 0; i < 4; i++) chk($sformatf("arb_order%0d", i), order[i], exp_ord[i]);
    chk("arb_m0_rdata", m0_rdata, exp_rd[0]);
    chk("arb_m1_rdata", m1_rdata, exp_rd[1]);

    // Randomized phase against a word-memory reference model
    for (int i = 0; i < 16; i++) rval[i] = 0;
    pend[0] = 0; pend[1] = 0; quiet[0] = 2; quiet[1] = 2;
    sl_rand = 1'b1;
    for (int cyc = 0; cyc < 6000; cyc++) begin
      @(negedge clk);
      if (cyc >= 3000 && !pend[0] && !pend[1]) break;
      if (s_read && s_write) chk("rnd_both_strobes", 1, 0);
      if (m0_ack && m1_ack) chk("rnd_both_acks", 1, 0);
      for (int n = 0; n < 2; n++) begin
        if ((n == 0) ? m0_ack : m1_ack) begin
          chk($sformatf("rnd_ack_owner%0d", n), pend[n], 1);
          chk($sformatf("rnd_err%0d", n), (n == 0) ? m0_err : m1_err, 0);
          if (pend[n]) begin
            if (m_we[n]) begin
              exp_v = rval[m_addr[n][3:0]] ? rmem[m_addr[n][3:0]] : dflt(m_addr[n][9:0]);
              for (int b = 0; b < 4; b++)
                if (m_mask[n][b]) exp_v[8*b +: 8] = m_wdata[n][8*b +: 8];
              rmem[m_addr[n][3:0]] = exp_v;
              rval[m_addr[n][3:0]] = 1;
            end else begin
              exp_rd[n] = rval[m_addr[n][3:0]] ? rmem[m_addr[n][3:0]] : dflt(m_addr[n][9:0]);
            end
          end
          chk($sformatf("rnd_m0_rdata_at_ack%0d", n), m0_rdata, exp_rd[0]);
          chk($sformatf("rnd_m1_rdata_at_ack%0d", n), m1_rdata, exp_rd[1]);
          pend[n] = 0; m_req[n] = 1'b0;
          quiet[n] = int'($urandom_range(0, 3));
        end
      end
      for (int n = 0; n < 2; n++) begin
        if (!pend[n]) begin
          if (quiet[n] > 0) quiet[n]--;
          else if (cyc < 3000 && $urandom_range(0, 2) == 0) begin
            m_we[n]    = $urandom_range(0, 1) == 1;
            m_addr[n]  = 32'h200 + $urandom_range(0, 15);
            m_wdata[n] = $urandom;
            m_mask[n]  = 4'($urandom_range(0, 15));
            m_req[n]   = 1'b1;
            pend[n]    = 1;
          end
        end
      end
    end
    chk("rnd_drained", {30'd0, pend[1], pend[0]}, 32'd0);
    m_req = 2'b00;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
